// File: rtl/grf_pkg.sv
// Shared definitions for the general-purpose register file: default sizes,
// the hardwired-zero index and a helper for locating packed port slices.
package grf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    // Bit offset of port idx inside a vector packing ports of the given width.
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/grf_wr_arbiter.sv
// Priority select over the write ports for one register index: reports
// whether any enabled port targets addr, the winning data, and any release.
import grf_pkg::*;

module grf_wr_arbiter #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NWRITE = 2
) (
    input  logic [ADDR_W-1:0]        addr,
    input  logic [NWRITE-1:0]        wr_en,
    input  logic [NWRITE*ADDR_W-1:0] wr_addr,
    input  logic [NWRITE*DATA_W-1:0] wr_data,
    input  logic [NWRITE-1:0]        wr_clr,
    output logic                     hit,
    output logic [DATA_W-1:0]        data,
    output logic                     clr
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
        hit  = 1'b0;
        data = '0;
        clr  = 1'b0;
        // Ascending scan: a later (higher-index) match overrides earlier ones.
        for (int p = 0; p < NWRITE; p++) begin
            if (wr_en[p] && (wr_addr[slice_lsb(p, ADDR_W) +: ADDR_W] == addr)) begin
                hit  = 1'b1;
                data = wr_data[slice_lsb(p, DATA_W) +: DATA_W];
                clr  = clr | wr_clr[p];
            end
        end
    end

endmodule

// File: rtl/grf_mp_scoreboard.sv
// Multi-port register file with write-to-read bypass and a per-register
// pending scoreboard used to stall consumers of multi-cycle results.
import grf_pkg::*;

module grf_mp_scoreboard #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREAD*ADDR_W-1:0]  rd_addr,
    output logic [NREAD*DATA_W-1:0]  rd_data,
    output logic [NREAD-1:0]         rd_busy,
    input  logic [NWRITE-1:0]        wr_en,
    input  logic [NWRITE*ADDR_W-1:0] wr_addr,
    input  logic [NWRITE*DATA_W-1:0] wr_data,
    input  logic [NWRITE-1:0]        wr_clr,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    logic [DATA_W-1:0] regs   [DEPTH];
    logic [DATA_W-1:0] wr_sel [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic [DEPTH-1:0]  wr_hit;
    logic [DEPTH-1:0]  clr_hit;
    logic [DEPTH-1:0]  claim_hit;
    logic [ADDR_W:0]   cnt_next;

    // Per-register write decode; index 0 is masked so it never writes, claims or clears.
    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(r);
        logic a_hit;
        logic a_clr;

        grf_wr_arbiter #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NWRITE (NWRITE)
        ) u_wr_arb (
            .addr    (IDX),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .wr_clr  (wr_clr),
            .hit     (a_hit),
            .data    (wr_sel[r]),
            .clr     (a_clr)
        );

        assign wr_hit[r]    = a_hit && (r != REG_ZERO);
        assign clr_hit[r]   = a_clr && (r != REG_ZERO);
        assign claim_hit[r] = claim_en && (claim_addr == IDX) && (r != REG_ZERO);
    end

    // A claim beats a same-cycle release: the claimant is a newer producer.
    always_comb begin
        busy_next = busy;
        cnt_next  = busy_cnt;
        if (|(claim_hit & ~busy)) begin
            cnt_next = cnt_next + CNT_ONE;
        end
        for (int r = 0; r < DEPTH; r++) begin
            if (claim_hit[r]) begin
                busy_next[r] = 1'b1;
            end else if (clr_hit[r]) begin
                busy_next[r] = 1'b0;
                if (busy[r]) begin
                    cnt_next = cnt_next - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every state element samples pre-edge values regardless of statement order.
        if (reset) begin
            busy     <= '0;
            busy_cnt <= '0;
            // NOTE: the storage array is cleared on reset because software relies on every register reading zero afterwards.
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
            for (int r = 0; r < DEPTH; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_sel[r];
                end
            end
        end
    end

    // Read ports: bypass the same-cycle write, and drop busy if that write releases it.
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              b_hit;
        logic              b_clr;
        logic [DATA_W-1:0] b_data;

        assign ra = rd_addr[i*ADDR_W +: ADDR_W];

        grf_wr_arbiter #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NWRITE (NWRITE)
        ) u_rd_arb (
            .addr    (ra),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .wr_clr  (wr_clr),
            .hit     (b_hit),
            .data    (b_data),
            .clr     (b_clr)
        );

        assign rd_data[i*DATA_W +: DATA_W] = (ra == ADDR_W'(REG_ZERO)) ? '0
                                           : (b_hit ? b_data : regs[ra]);
        assign rd_busy[i] = busy[ra] & ~b_clr;
    end

endmodule

// File: tb/tb_grf_mp_scoreboard.sv
// Directed bench for grf_mp_scoreboard: stimulus queues expectations tagged
// with the cycle they are due; a monitor pops and compares on the falling edge.
module tb_grf_mp_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    typedef enum {E_DATA, E_BUSY, E_CNT} kind_e;
    typedef struct {
        int          cyc;
        kind_e       kind;
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic [NW-1:0]    wr_clr;
    logic             claim_en;
    logic [AW-1:0]    claim_addr;
    logic [AW:0]      busy_cnt;

    int   cycle = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t e;
    logic [31:0] act;

    grf_mp_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .NWRITE(NW)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_clr     (wr_clr),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .busy_cnt   (busy_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: outputs are stable mid-cycle; compare everything due by now.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cycle) begin
            e = q.pop_front();
            case (e.kind)
                E_DATA:  act = rd_data[e.port*DW +: DW];
                E_BUSY:  act = {31'b0, rd_busy[e.port]};
                default: act = {26'b0, busy_cnt};
            endcase
            total = total + 1;
            if (e.cyc != cycle || act !== e.val) begin
                bad = bad + 1;
                $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                         e.name, act, e.val, cycle, e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en      = '0;
        wr_clr     = '0;
        wr_addr    = '0;
        wr_data    = '0;
        claim_en   = 1'b0;
        claim_addr = '0;
    endtask

    task automatic wr(input int p, input logic en, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic c);
        wr_en[p]             = en;
        wr_addr[p*AW +: AW]  = a;
        wr_data[p*DW +: DW]  = d;
        wr_clr[p]            = c;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic claim(input logic [AW-1:0] a);
        claim_en   = 1'b1;
        claim_addr = a;
    endtask

    task automatic expect_at(input int off, input kind_e k, input int p,
                             input logic [31:0] v, input string n);
        exp_t x;
        x.cyc  = cycle + off;
        x.kind = k;
        x.port = p;
        x.val  = v;
        x.name = n;
        q.push_back(x);
    endtask

    initial begin
        reset   = 1'b1;
        rd_addr = '0;
        idle();
        step();

        // Reset state, then a write that the following reset must wipe.
        reset = 1'b0;
        rd(0, 5); rd(1, 0);
        wr(0, 1'b1, 5, 32'h1234, 1'b0);
        expect_at(0, E_DATA, 0, 32'h1234, "rst_bypass_r5");
        expect_at(0, E_DATA, 1, 32'h0,    "rst_r0");
        expect_at(0, E_BUSY, 0, 32'h0,    "rst_busy");
        expect_at(0, E_CNT,  0, 32'h0,    "rst_cnt");
        step();
        idle(); reset = 1'b1;
        claim(7);
        wr(1, 1'b1, 6, 32'hABCD, 1'b1);
        expect_at(0, E_DATA, 0, 32'h1234, "stored_r5");
        step();
        idle(); reset = 1'b0;
        rd(1, 7);
        expect_at(0, E_DATA, 0, 32'h0, "reset_r5");
        expect_at(0, E_BUSY, 0, 32'h0, "reset_busy_r5");
        expect_at(0, E_BUSY, 1, 32'h0, "reset_claim_r7");
        expect_at(0, E_CNT,  0, 32'h0, "reset_cnt");
        step();

        // Bypass and hold.
        wr(0, 1'b1, 8, 32'hDEADBEEF, 1'b0);
        rd(0, 8); rd(1, 6);
        expect_at(0, E_DATA, 0, 32'hDEADBEEF, "bypass_r8");
        expect_at(0, E_DATA, 1, 32'h0,        "reset_write_r6");
        step();
        idle();
        expect_at(0, E_DATA, 0, 32'hDEADBEEF, "hold_r8");
        step();

        // Write-port priority.
        wr(0, 1'b1, 3, 32'h11, 1'b0);
        wr(1, 1'b1, 3, 32'h22, 1'b0);
        rd(0, 3);
        expect_at(0, E_DATA, 0, 32'h22, "prio_bypass_r3");
        step();
        idle();
        expect_at(0, E_DATA, 0, 32'h22, "prio_stored_r3");
        step();

        // Scoreboard lifecycle on r9.
        claim(9); rd(0, 9);
        expect_at(0, E_BUSY, 0, 32'h0, "claim_same_cycle");
        expect_at(0, E_CNT,  0, 32'h0, "claim_cnt_before");
        step();
        idle();
        expect_at(0, E_BUSY, 0, 32'h1, "claim_busy_r9");
        expect_at(0, E_CNT,  0, 32'h1, "claim_cnt");
        step();
        wr(1, 1'b1, 9, 32'h55, 1'b1);
        expect_at(0, E_BUSY, 0, 32'h0,  "clr_busy_same");
        expect_at(0, E_DATA, 0, 32'h55, "clr_bypass_r9");
        expect_at(0, E_CNT,  0, 32'h1,  "clr_cnt_before");
        step();
        idle();
        expect_at(0, E_BUSY, 0, 32'h0,  "clr_busy_after");
        expect_at(0, E_DATA, 0, 32'h55, "clr_stored_r9");
        expect_at(0, E_CNT,  0, 32'h0,  "clr_cnt_after");
        step();

        // Write without clr keeps busy; clr without wr_en does nothing.
        claim(10); rd(1, 10);
        expect_at(0, E_BUSY, 1, 32'h0, "claim_r10_same");
        step();
        idle();
        wr(0, 1'b1, 10, 32'h66, 1'b0);
        wr(1, 1'b0, 10, 32'h99, 1'b1);
        expect_at(0, E_BUSY, 1, 32'h1,  "noclr_busy_r10");
        expect_at(0, E_DATA, 1, 32'h66, "noclr_bypass_r10");
        expect_at(0, E_CNT,  0, 32'h1,  "noclr_cnt");
        step();
        idle();
        expect_at(0, E_BUSY, 1, 32'h1,  "noclr_busy_hold");
        expect_at(0, E_DATA, 1, 32'h66, "noclr_stored_r10");
        expect_at(0, E_CNT,  0, 32'h1,  "noclr_cnt_hold");
        step();

        // Release r10 while claiming r9: count stays at one.
        wr(0, 1'b1, 10, 32'h67, 1'b1);
        claim(9); rd(0, 9);
        expect_at(0, E_BUSY, 1, 32'h0,  "swap_busy_r10");
        expect_at(0, E_DATA, 1, 32'h67, "swap_bypass_r10");
        expect_at(0, E_BUSY, 0, 32'h0,  "swap_busy_r9_same");
        expect_at(0, E_CNT,  0, 32'h1,  "swap_cnt_before");
        step();
        idle();
        expect_at(0, E_BUSY, 0, 32'h1, "swap_busy_r9");
        expect_at(0, E_BUSY, 1, 32'h0, "swap_free_r10");
        expect_at(0, E_CNT,  0, 32'h1, "swap_cnt_after");
        step();

        // Claim and clear of the same register: claim wins.
        claim(9);
        wr(0, 1'b1, 9, 32'h77, 1'b1);
        expect_at(0, E_BUSY, 0, 32'h0,  "coll_busy_same");
        expect_at(0, E_DATA, 0, 32'h77, "coll_bypass_r9");
        step();
        idle();
        expect_at(0, E_BUSY, 0, 32'h1,  "coll_busy_after");
        expect_at(0, E_DATA, 0, 32'h77, "coll_stored_r9");
        expect_at(0, E_CNT,  0, 32'h1,  "coll_cnt");
        step();

        // Re-claim of a busy register leaves the count alone.
        claim(9);
        step();
        idle();
        claim(11);
        expect_at(0, E_CNT,  0, 32'h1, "reclaim_cnt");
        expect_at(0, E_BUSY, 0, 32'h1, "reclaim_busy_r9");
        step();

        // Two releases in one cycle.
        idle();
        wr(0, 1'b1, 9,  32'h88, 1'b1);
        wr(1, 1'b1, 11, 32'h99, 1'b1);
        rd(1, 11);
        expect_at(0, E_CNT,  0, 32'h2, "dual_cnt_before");
        expect_at(0, E_BUSY, 0, 32'h0, "dual_busy_r9");
        expect_at(0, E_BUSY, 1, 32'h0, "dual_busy_r11");
        step();

        // Register zero ignores writes and claims.
        idle();
        wr(0, 1'b1, 0, 32'hFFFFFFFF, 1'b1);
        wr(1, 1'b1, 0, 32'h12345678, 1'b0);
        claim(0); rd(0, 0); rd(1, 0);
        expect_at(0, E_DATA, 0, 32'h0, "zero_bypass_p0");
        expect_at(0, E_DATA, 1, 32'h0, "zero_bypass_p1");
        expect_at(0, E_BUSY, 0, 32'h0, "zero_busy_same");
        expect_at(0, E_CNT,  0, 32'h0, "dual_cnt_after");
        step();
        idle();
        rd(1, 11);
        expect_at(0, E_DATA, 0, 32'h0,  "zero_stored");
        expect_at(0, E_BUSY, 0, 32'h0,  "zero_busy_after");
        expect_at(0, E_CNT,  0, 32'h0,  "zero_cnt");
        expect_at(0, E_DATA, 1, 32'h99, "dual_stored_r11");
        step();

        // Drain: every queued expectation is due by now.
        for (int i = 0; i < 3; i++) step();
        if (q.size() != 0) begin
            $display("FAIL drain: got %0d pending expected 0", q.size());
            $fatal(1, "scoreboard not drained");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
